// File: rtl/cpu_pkg.sv
// Shared definitions for the simple datapath CPU front end: opcode and
// ALU operation encodings, instruction field positions, the issue FSM
// state type and small decode helpers.
package cpu_pkg;

  localparam int INSTR_W = 16;

  // Major opcodes recognised by the issue stage
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_ALU = 3'b101;

  // MOV sub-operations carried in the ALU_op field
  localparam logic [1:0] MOV_REG = 2'b00;
  localparam logic [1:0] MOV_IMM = 2'b10;

  // ALU operation encodings
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_CMP = 2'b01,
    ALU_AND = 2'b10,
    ALU_MVN = 2'b11
  } alu_op_t;

  // Instruction field bit positions
  localparam int OPC_HI   = 15;
  localparam int OPC_LO   = 13;
  localparam int ALUOP_HI = 12;
  localparam int ALUOP_LO = 11;
  localparam int RN_HI    = 10;
  localparam int RN_LO    = 8;
  localparam int RD_HI    = 7;
  localparam int RD_LO    = 5;
  localparam int SH_HI    = 4;
  localparam int SH_LO    = 3;
  localparam int RM_HI    = 2;
  localparam int RM_LO    = 0;
  localparam int IMM8_HI  = 7;
  localparam int IMM5_HI  = 4;

  // Issue FSM states
  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ISSUE   = 2'b01,
    S_WAIT_LO = 2'b10,
    S_WAIT_HI = 2'b11
  } issue_state_t;

  // Only MOV-immediate, MOV-register and every ALU operation can be issued
  function automatic logic is_legal(input logic [2:0] opc, input logic [1:0] alu_op);
    return (opc == OP_ALU) ||
           ((opc == OP_MOV) && ((alu_op == MOV_IMM) || (alu_op == MOV_REG)));
  endfunction

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  function automatic logic [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small instruction buffer between the sender and the issue FSM.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// A push while full is taken only when a pop happens in the same cycle.
module instr_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = INSTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset flushes the buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset because count guards reads
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_issue.sv
// Instruction issue front end: buffers incoming 16-bit instructions,
// decodes the head entry, pulses start to the controller and retires the
// head once the controller's waiting flag has fallen and risen again.
// Illegal heads are dropped with a one-cycle err_illegal pulse.
// Optional macro ISSUE_TIMEOUT_EN adds a WAIT_LO watchdog with the
// TIMEOUT parameter and an err_timeout output.
module instr_issue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
`ifdef ISSUE_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 16
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  output logic        in_ready,
  input  logic        waiting,
  output logic        start,
  output logic [2:0]  opcode,
  output logic [1:0]  ALU_op,
  output logic [1:0]  shift_op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [2:0]  rm,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic        err_illegal,
`ifdef ISSUE_TIMEOUT_EN
  output logic        err_timeout,
`endif
  output logic [7:0]  issued_count
);

  issue_state_t state;
  logic [15:0]  head;
  logic         fifo_full;
  logic         fifo_empty;
  logic         push;
  logic         pop;
  logic         head_legal;

`ifdef ISSUE_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_cnt;
  logic           wd_expired;
  // wd_cnt holds the number of cycles since start; it expires one cycle
  // early so err_timeout becomes visible exactly TIMEOUT cycles after start
  assign wd_expired = (wd_cnt == WDW'(TIMEOUT - 1));
`endif

  assign in_ready   = !fifo_full;
  assign push       = in_valid && in_ready;
  assign head_legal = is_legal(head[OPC_HI:OPC_LO], head[ALUOP_HI:ALUOP_LO]);

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_instr),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head removal: drop illegal heads in IDLE, retire on waiting rising in WAIT_HI
  always_comb begin
    pop = 1'b0;
    case (state)
      S_IDLE:    pop = !fifo_empty && !head_legal;
      S_WAIT_HI: pop = waiting;
`ifdef ISSUE_TIMEOUT_EN
      S_WAIT_LO: pop = waiting && wd_expired;
`endif
      default:   pop = 1'b0;
    endcase
  end

  // Issue FSM with registered start, error pulses, decode outputs and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      start        <= 1'b0;
      err_illegal  <= 1'b0;
      issued_count <= 8'd0;
      opcode       <= 3'd0;
      ALU_op       <= 2'd0;
      shift_op     <= 2'd0;
      rn           <= 3'd0;
      rd           <= 3'd0;
      rm           <= 3'd0;
      sximm8       <= 16'd0;
      sximm5       <= 16'd0;
`ifdef ISSUE_TIMEOUT_EN
      err_timeout  <= 1'b0;
      wd_cnt       <= '0;
`endif
    end else begin
      start       <= 1'b0;
      err_illegal <= 1'b0;
`ifdef ISSUE_TIMEOUT_EN
      err_timeout <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            if (!head_legal) begin
              err_illegal <= 1'b1;
            end else if (waiting) begin
              state    <= S_ISSUE;
              start    <= 1'b1;
              opcode   <= head[OPC_HI:OPC_LO];
              ALU_op   <= head[ALUOP_HI:ALUOP_LO];
              shift_op <= head[SH_HI:SH_LO];
              rn       <= head[RN_HI:RN_LO];
              rd       <= head[RD_HI:RD_LO];
              rm       <= head[RM_HI:RM_LO];
              sximm8   <= sext8(head[IMM8_HI:0]);
              sximm5   <= sext5(head[IMM5_HI:0]);
            end
          end
        end
        S_ISSUE: begin
          state <= S_WAIT_LO;
`ifdef ISSUE_TIMEOUT_EN
          wd_cnt <= WDW'(1);
`endif
        end
        S_WAIT_LO: begin
          if (!waiting) begin
            state <= S_WAIT_HI;
          end
`ifdef ISSUE_TIMEOUT_EN
          else if (wd_expired) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + WDW'(1);
          end
`endif
        end
        S_WAIT_HI: begin
          if (waiting) begin
            issued_count <= issued_count + 8'd1;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
